fetch_queue_unit: RTL and testbench

// - Parametrised instruction-fetch stage with an internal prefetch queue. It owns the PC and drives
//   a combinational-read instruction memory port.
// - Buffers up to DEPTH {pc, inst} entries so fetch keeps running while decode stalls.
// - Presents the queue head to the IF/ID boundary with a valid flag. A redirect (jump) flushes the queue.

---
 rtl/fetch_queue_unit.sv | 120 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Owns the PC, drives a combinational-read instruction memory, and presents the
// queue head to decode. A jump flushes every queued entry and redirects the PC.
// Optional build macro: FETCH_PERF_CNT_EN adds 32-bit fetch/stall/flush counters.
module fetch_queue_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INST_WIDTH-1:0] BUBBLE_INST = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stallFromDecode,
  input  logic                    jumpEnable,
  input  logic [ADDR_WIDTH-1:0]   jumpValue,
  output logic [ADDR_WIDTH-1:0]   imemAddr,
  input  logic [INST_WIDTH-1:0]   imemData,
  output logic                    fetchValid,
  output logic [ADDR_WIDTH-1:0]   fetchPc,
  output logic [INST_WIDTH-1:0]   fetchInst,
  output logic [$clog2(DEPTH):0]  queueCount
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]             perfFetchCount,
  output logic [31:0]             perfStallCount,
  output logic [31:0]             perfFlushCount
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Sequential PC advance; the add is truncated so the address space wraps.
  function automatic logic [ADDR_WIDTH-1:0] nextPc(input logic [ADDR_WIDTH-1:0] cur);
    return cur + ADDR_WIDTH'(4);
  endfunction

  // Jump targets are forced to word alignment by clearing the two low bits.
  function automatic logic [ADDR_WIDTH-1:0] alignTarget(input logic [ADDR_WIDTH-1:0] target);
    return target & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  endfunction

  logic [ADDR_WIDTH-1:0] pc;
  logic [PTR_W-1:0]      headPtr;
  logic [PTR_W-1:0]      tailPtr;
  logic [CNT_W-1:0]      count;

  // Queue payload; never reset because occupancy alone decides what is visible.
  logic [ADDR_WIDTH-1:0] pcQueue   [DEPTH];
  logic [INST_WIDTH-1:0] instQueue [DEPTH];

  logic queueFull;
  logic pop;
  logic push;

  assign queueFull  = (count == CNT_W'(DEPTH));
  assign fetchValid = (count != '0);
  // A jump blocks both ends of the queue: the head is discarded, not consumed.
  assign pop        = fetchValid && !stallFromDecode && !jumpEnable;
  // A full queue can still accept a new word in the same cycle the head leaves.
  assign push       = !jumpEnable && (!queueFull || pop);

  assign imemAddr   = pc;
  assign queueCount = count;
  assign fetchPc    = fetchValid ? pcQueue[headPtr]   : '0;
  assign fetchInst  = fetchValid ? instQueue[headPtr] : BUBBLE_INST;

  // Control state: PC, pointers and occupancy; jump flushes and redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_PC;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (jumpEnable) begin
      pc      <= alignTarget(jumpValue);
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        pc      <= nextPc(pc);
        tailPtr <= tailPtr + 1'b1;
      end
      if (pop) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload capture: the word read at the current PC lands at the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      pcQueue[tailPtr]   <= pc;
      instQueue[tailPtr] <= imemData;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters; they wrap silently at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perfFetchCount <= '0;
      perfStallCount <= '0;
      perfFlushCount <= '0;
    end else begin
      if (push)                          perfFetchCount <= perfFetchCount + 32'd1;
      if (fetchValid && stallFromDecode) perfStallCount <= perfStallCount + 32'd1;
      if (jumpEnable)                    perfFlushCount <= perfFlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: reset, streaming, stall/backpressure,
// jump flush (with and without stall), PC wraparound and mid-run reset.
// Memory model returns the bitwise complement of the address as the instruction.
module tb_fetch_queue_unit;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, stall = 1'b0, jumpEn = 1'b0;
  logic [31:0] jumpVal = '0;
  logic [31:0] imemAddr, imemData, fetchPc, fetchInst;
  logic        fetchValid;
  logic [2:0]  queueCount;

  logic        wReset = 1'b1, wStall = 1'b0, wJumpEn = 1'b0;
  logic [31:0] wJumpVal = '0;
  logic [31:0] wImemAddr, wImemData, wFetchPc, wFetchInst;
  logic        wFetchValid;
  logic [2:0]  wQueueCount;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetch, perfStall, perfFlush;
  logic [31:0] wPerfFetch, wPerfStall, wPerfFlush;
`endif

  int total = 0;
  int bad = 0;

  assign imemData  = ~imemAddr;
  assign wImemData = ~wImemAddr;

  fetch_queue_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4),
                     .RESET_PC(32'h0), .BUBBLE_INST(BUBBLE)) dut (
    .clock(clock), .reset(reset), .stallFromDecode(stall), .jumpEnable(jumpEn),
    .jumpValue(jumpVal), .imemAddr(imemAddr), .imemData(imemData),
    .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchInst(fetchInst),
    .queueCount(queueCount)
`ifdef FETCH_PERF_CNT_EN
    , .perfFetchCount(perfFetch), .perfStallCount(perfStall), .perfFlushCount(perfFlush)
`endif
  );

  fetch_queue_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4),
                     .RESET_PC(WRAP_PC), .BUBBLE_INST(BUBBLE)) dutWrap (
    .clock(clock), .reset(wReset), .stallFromDecode(wStall), .jumpEnable(wJumpEn),
    .jumpValue(wJumpVal), .imemAddr(wImemAddr), .imemData(wImemData),
    .fetchValid(wFetchValid), .fetchPc(wFetchPc), .fetchInst(wFetchInst),
    .queueCount(wQueueCount)
`ifdef FETCH_PERF_CNT_EN
    , .perfFetchCount(wPerfFetch), .perfStallCount(wPerfStall), .perfFlushCount(wPerfFlush)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; stall = 1'b0; jumpEn = 1'b0; jumpVal = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; jumpEn = 1'b0;
    step();
    total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fetchValid); end
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", queueCount); end
    total++; if (fetchPc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", fetchPc); end
    total++; if (fetchInst !== BUBBLE) begin bad++; $display("FAIL reset_inst got=%h want=%h", fetchInst, BUBBLE); end
    total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", imemAddr); end
`ifdef FETCH_PERF_CNT_EN
    total++; if ({perfFetch, perfStall, perfFlush} !== 96'h0) begin bad++; $display("FAIL reset_perf got=%h/%h/%h want=0", perfFetch, perfStall, perfFlush); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_stream();
    doReset();
    total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%b want=0", fetchValid); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (fetchValid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, fetchValid); end
      total++; if (fetchPc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, fetchPc, 32'(4 * i)); end
      total++; if (fetchInst !== ~32'(4 * i)) begin bad++; $display("FAIL stream_inst[%0d] got=%h want=%h", i, fetchInst, ~32'(4 * i)); end
      total++; if (queueCount !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", i, queueCount); end
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (perfFetch !== 32'd6) begin bad++; $display("FAIL stream_perf_fetch got=%0d want=6", perfFetch); end
`endif
  endtask

  task automatic test_stall();
    int expCount;
    logic [31:0] expPc;
    doReset();
    step(); step(); step();
    total++; if (fetchPc !== 32'h8) begin bad++; $display("FAIL stall_start_pc got=%h want=8", fetchPc); end
    stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      expCount = (k + 1 > 4) ? 4 : k + 1;
      total++; if (fetchPc !== 32'h8) begin bad++; $display("FAIL stall_hold_pc[%0d] got=%h want=8", k, fetchPc); end
      total++; if (queueCount !== 3'(expCount)) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=%0d", k, queueCount, expCount); end
    end
    total++; if (imemAddr !== 32'h18) begin bad++; $display("FAIL stall_addr got=%h want=18", imemAddr); end
    stall = 1'b0;
    expPc = 32'h8;
    for (int i = 0; i < 5; i++) begin
      total++; if (fetchPc !== expPc) begin bad++; $display("FAIL release_pc[%0d] got=%h want=%h", i, fetchPc, expPc); end
      total++; if (fetchInst !== ~expPc) begin bad++; $display("FAIL release_inst[%0d] got=%h want=%h", i, fetchInst, ~expPc); end
      total++; if (queueCount !== 3'd4) begin bad++; $display("FAIL release_count[%0d] got=%0d want=4", i, queueCount); end
      step();
      expPc = expPc + 32'h4;
    end
  endtask

  task automatic test_jump();
    doReset();
    step();
    stall = 1'b1;
    step(); step();
    total++; if (queueCount !== 3'd3) begin bad++; $display("FAIL jump_pre_count got=%0d want=3", queueCount); end
    stall = 1'b0; jumpEn = 1'b1; jumpVal = 32'h1003;
    step();
    jumpEn = 1'b0;
    total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL jump_valid got=%b want=0", fetchValid); end
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL jump_count got=%0d want=0", queueCount); end
    total++; if (imemAddr !== 32'h1000) begin bad++; $display("FAIL jump_addr got=%h want=1000", imemAddr); end
    total++; if (fetchPc !== 32'h0) begin bad++; $display("FAIL jump_bubble_pc got=%h want=0", fetchPc); end
    total++; if (fetchInst !== BUBBLE) begin bad++; $display("FAIL jump_bubble_inst got=%h want=%h", fetchInst, BUBBLE); end
    step();
    total++; if (fetchValid !== 1'b1) begin bad++; $display("FAIL jump_target_valid got=%b want=1", fetchValid); end
    total++; if (fetchPc !== 32'h1000) begin bad++; $display("FAIL jump_target_pc got=%h want=1000", fetchPc); end
    total++; if (fetchInst !== ~32'h1000) begin bad++; $display("FAIL jump_target_inst got=%h want=%h", fetchInst, ~32'h1000); end
    step();
    total++; if (fetchPc !== 32'h1004) begin bad++; $display("FAIL jump_next_pc got=%h want=1004", fetchPc); end
  endtask

  task automatic test_jump_stall();
    doReset();
    step();
    stall = 1'b1;
    step(); step(); step(); step();
    total++; if (queueCount !== 3'd4) begin bad++; $display("FAIL jstall_full got=%0d want=4", queueCount); end
    total++; if (fetchPc !== 32'h0) begin bad++; $display("FAIL jstall_head got=%h want=0", fetchPc); end
    jumpEn = 1'b1; jumpVal = 32'h2000;
    step();
    jumpEn = 1'b0; stall = 1'b0;
    total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL jstall_valid got=%b want=0", fetchValid); end
    total++; if (imemAddr !== 32'h2000) begin bad++; $display("FAIL jstall_addr got=%h want=2000", imemAddr); end
    step();
    total++; if (fetchValid !== 1'b1) begin bad++; $display("FAIL jstall_target_valid got=%b want=1", fetchValid); end
    total++; if (fetchPc !== 32'h2000) begin bad++; $display("FAIL jstall_target_pc got=%h want=2000", fetchPc); end
    step();
    total++; if (fetchPc !== 32'h2004) begin bad++; $display("FAIL jstall_next_pc got=%h want=2004", fetchPc); end
  endtask

  task automatic test_pc_wrap();
    wReset = 1'b1;
    step();
    wReset = 1'b0;
    total++; if (wImemAddr !== WRAP_PC) begin bad++; $display("FAIL wrap_addr got=%h want=%h", wImemAddr, WRAP_PC); end
    total++; if (wQueueCount !== 3'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", wQueueCount); end
`ifdef FETCH_PERF_CNT_EN
    total++; if ({wPerfFetch, wPerfStall, wPerfFlush} !== 96'h0) begin bad++; $display("FAIL wrap_perf got=%h/%h/%h want=0", wPerfFetch, wPerfStall, wPerfFlush); end
`endif
    step();
    total++; if (wFetchValid !== 1'b1 || wFetchPc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%b/%h want=1/fffffff8", wFetchValid, wFetchPc); end
    step();
    total++; if (wFetchPc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc1 got=%h want=fffffffc", wFetchPc); end
    step();
    total++; if (wFetchPc !== 32'h0) begin bad++; $display("FAIL wrap_pc2 got=%h want=0", wFetchPc); end
    total++; if (wFetchInst !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_inst2 got=%h want=ffffffff", wFetchInst); end
  endtask

  task automatic test_reset_mid();
    doReset();
    step();
    stall = 1'b1;
    step(); step(); step(); step();
    total++; if (queueCount !== 3'd4) begin bad++; $display("FAIL rmid_full got=%0d want=4", queueCount); end
    reset = 1'b1;
    step();
    total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", fetchValid); end
    total++; if (fetchInst !== BUBBLE) begin bad++; $display("FAIL rmid_inst got=%h want=%h", fetchInst, BUBBLE); end
    total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h want=0", imemAddr); end
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", queueCount); end
`ifdef FETCH_PERF_CNT_EN
    total++; if ({perfFetch, perfStall, perfFlush} !== 96'h0) begin bad++; $display("FAIL rmid_perf got=%h/%h/%h want=0", perfFetch, perfStall, perfFlush); end
`endif
    reset = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_stall();
    test_pc_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
